// File: rtl/sdio_data_sequencer_pkg.sv
// Shared SDIO types for the data sequencer: the data4 byte-count type and the
// sequencer state encoding.
package sdio_data_sequencer_pkg;

    typedef logic [9:0] type_data4_count;

    typedef enum logic [2:0] {
        IDLE,
        TX_DELAY,
        TX_WAIT,
        TX_FETCH,
        TX_PRESENT,
        RX_RECV
    } seq_state_t;

    // A data4 count of zero stands for a full 512-byte block.
    localparam int unsigned FULL_BLOCK = 512;

endpackage

// File: rtl/sdio_data_sequencer.sv
// Sequences SDIO data4 block transfers between the response engine / read
// front-end and an external 512-byte buffer RAM.
module sdio_data_sequencer
    import sdio_data_sequencer_pkg::*;
#(
    parameter int unsigned START_DELAY = 2
)
(
    input  logic            clock,
    input  logic            reset,

    input  type_data4_count data4_count,
    input  logic            write_data4_strobe,
    input  logic            read_data4_strobe,

    output logic            response_start_write,
    input  logic            response_data_req,
    output logic            response_data_strobe,
    output logic            response_data_empty,
    output logic [7:0]      response_data,

    input  logic            read_byte_strobe,
    input  logic [7:0]      read_byte,
    input  logic            read_all_strobe,
    input  logic            read_crc_ok4,

    output logic [8:0]      mem_addr,
    input  logic [7:0]      mem_rd_data,
    output logic            mem_wr_en,
    output logic [7:0]      mem_wr_data,

    output logic            busy,
    output logic            tx_done,
    output logic            rx_done,
    output logic            rx_crc_ok,
    output logic            rx_overflow,
    output logic            proto_error
);

    localparam logic [3:0] DELAY_LAST = 4'(START_DELAY - 1);

    seq_state_t      state;
    seq_state_t      state_next;
    type_data4_count count;
    type_data4_count index;
    type_data4_count count_load;
    logic [3:0]      delay_cnt;
    logic [7:0]      data_reg;
    logic            empty_reg;
    logic            rx_done_reg;
    logic            perr_reg;
    logic            crc_reg;
    logic            ovf_reg;

    logic start_tx;
    logic start_rx;
    logic strobe_err;
    logic delay_done;
    logic tx_req_end;
    logic rx_write;
    logic rx_finish;

    assign count_load = (data4_count == '0) ? type_data4_count'(FULL_BLOCK) : data4_count;
    assign start_tx   = (state == IDLE) && write_data4_strobe;
    assign start_rx   = (state == IDLE) && read_data4_strobe && !write_data4_strobe;
    // Any data4 strobe that cannot start a transfer is a protocol error.
    assign strobe_err = (write_data4_strobe || read_data4_strobe) &&
                        ((state != IDLE) || (write_data4_strobe && read_data4_strobe));
    assign delay_done = (state == TX_DELAY) && (delay_cnt == DELAY_LAST);
    assign tx_req_end = (state == TX_WAIT) && response_data_req && !(index < count);
    assign rx_write   = (state == RX_RECV) && read_byte_strobe && (index < count);
    assign rx_finish  = (state == RX_RECV) && read_all_strobe;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (write_data4_strobe) begin
                    state_next = TX_DELAY;
                end else if (read_data4_strobe) begin
                    state_next = RX_RECV;
                end
            end
            TX_DELAY: begin
                if (delay_done) begin
                    state_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (response_data_req) begin
                    state_next = (index < count) ? TX_FETCH : IDLE;
                end
            end
            TX_FETCH:   state_next = TX_PRESENT;
            TX_PRESENT: state_next = TX_WAIT;
            RX_RECV: begin
                if (read_all_strobe) begin
                    state_next = IDLE;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        response_start_write = delay_done;
        response_data_strobe = (state == TX_PRESENT);
        mem_wr_en            = rx_write;
        mem_wr_data          = rx_write ? read_byte : 8'h00;
        busy                 = (state != IDLE);
    end

    // Index, count and the registered (one-cycle-late) status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            index       <= '0;
            delay_cnt   <= '0;
            data_reg    <= '0;
            empty_reg   <= 1'b0;
            rx_done_reg <= 1'b0;
            perr_reg    <= 1'b0;
            crc_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            empty_reg   <= tx_req_end;
            rx_done_reg <= rx_finish;
            perr_reg    <= strobe_err;

            if (start_tx || start_rx) begin
                count <= count_load;
                index <= '0;
            end else if ((state == TX_PRESENT) || rx_write) begin
                index <= index + 10'd1;
            end

            if (state == TX_DELAY) begin
                delay_cnt <= delay_cnt + 4'd1;
            end else begin
                delay_cnt <= '0;
            end

            if (state == TX_FETCH) begin
                data_reg <= mem_rd_data;
            end

            if (start_rx) begin
                crc_reg <= 1'b0;
            end else if (rx_finish) begin
                crc_reg <= read_crc_ok4;
            end

            if ((state == RX_RECV) && read_byte_strobe && !(index < count)) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign mem_addr            = index[8:0];
    assign response_data       = data_reg;
    assign response_data_empty = empty_reg;
    assign tx_done             = empty_reg;
    assign rx_done             = rx_done_reg;
    assign proto_error         = perr_reg;
    assign rx_crc_ok           = crc_reg;
    assign rx_overflow         = ovf_reg;

endmodule

// File: tb/tb_sdio_data_sequencer.sv
// Scoreboard bench for sdio_data_sequencer: stimulus queues the expected
// pulses with their due cycle, a negedge monitor pops and compares them.
module tb_sdio_data_sequencer;
    import sdio_data_sequencer_pkg::*;

    localparam int SD = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    type_data4_count data4_count = '0;
    logic            write_data4_strobe = 1'b0;
    logic            read_data4_strobe = 1'b0;
    logic            response_start_write;
    logic            response_data_req = 1'b0;
    logic            response_data_strobe;
    logic            response_data_empty;
    logic [7:0]      response_data;
    logic            read_byte_strobe = 1'b0;
    logic [7:0]      read_byte = 8'h00;
    logic            read_all_strobe = 1'b0;
    logic            read_crc_ok4 = 1'b0;
    logic [8:0]      mem_addr;
    logic [7:0]      mem_rd_data = 8'h00;
    logic            mem_wr_en;
    logic [7:0]      mem_wr_data;
    logic            busy;
    logic            tx_done;
    logic            rx_done;
    logic            rx_crc_ok;
    logic            rx_overflow;
    logic            proto_error;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t        q_start[$];
    ev_t        q_strobe[$];
    ev_t        q_empty[$];
    ev_t        q_txdone[$];
    ev_t        q_rxdone[$];
    ev_t        q_wr[$];
    ev_t        q_perr[$];
    logic [7:0] byte_q[$];
    logic [7:0] buffer [512];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         model_overflow = 1'b0;

    sdio_data_sequencer #(.START_DELAY(SD)) dut (
        .clock                (clock),
        .reset                (reset),
        .data4_count          (data4_count),
        .write_data4_strobe   (write_data4_strobe),
        .read_data4_strobe    (read_data4_strobe),
        .response_start_write (response_start_write),
        .response_data_req    (response_data_req),
        .response_data_strobe (response_data_strobe),
        .response_data_empty  (response_data_empty),
        .response_data        (response_data),
        .read_byte_strobe     (read_byte_strobe),
        .read_byte            (read_byte),
        .read_all_strobe      (read_all_strobe),
        .read_crc_ok4         (read_crc_ok4),
        .mem_addr             (mem_addr),
        .mem_rd_data          (mem_rd_data),
        .mem_wr_en            (mem_wr_en),
        .mem_wr_data          (mem_wr_data),
        .busy                 (busy),
        .tx_done              (tx_done),
        .rx_done              (rx_done),
        .rx_crc_ok            (rx_crc_ok),
        .rx_overflow          (rx_overflow),
        .proto_error          (proto_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // External buffer RAM with one cycle of read latency.
    always @(posedge clock) mem_rd_data <= buffer[mem_addr];

    function automatic ev_t mk(input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pop_check(input string name, input int kind, input int val);
        ev_t e;
        bit  found;
        found = 1'b1;
        e = mk(0, 0);
        case (kind)
            0: if (q_start.size() > 0)  e = q_start.pop_front();  else found = 1'b0;
            1: if (q_strobe.size() > 0) e = q_strobe.pop_front(); else found = 1'b0;
            2: if (q_empty.size() > 0)  e = q_empty.pop_front();  else found = 1'b0;
            3: if (q_txdone.size() > 0) e = q_txdone.pop_front(); else found = 1'b0;
            4: if (q_rxdone.size() > 0) e = q_rxdone.pop_front(); else found = 1'b0;
            5: if (q_wr.size() > 0)     e = q_wr.pop_front();     else found = 1'b0;
            default: if (q_perr.size() > 0) e = q_perr.pop_front(); else found = 1'b0;
        endcase
        if (!found) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: unexpected pulse at cycle %0d value %0d, want no pulse", name, cyc, val);
        end else begin
            checkOutput({name, " cycle"}, cyc, e.cyc);
            checkOutput({name, " value"}, val, e.val);
        end
    endtask

    always @(negedge clock) begin
        if (response_start_write === 1'b1) pop_check("start_write", 0, 1);
        if (response_data_strobe === 1'b1) pop_check("data_strobe", 1, int'(response_data));
        if (response_data_empty === 1'b1)  pop_check("data_empty", 2, 1);
        if (tx_done === 1'b1)              pop_check("tx_done", 3, 1);
        if (rx_done === 1'b1)              pop_check("rx_done", 4, 1);
        if (mem_wr_en === 1'b1)            pop_check("mem_write", 5, int'(mem_addr) * 256 + int'(mem_wr_data));
        if (proto_error === 1'b1)          pop_check("proto_error", 6, 1);
    end

    // Drive one cycle of inputs, then return just after the next rising edge.
    task automatic applyStimulus(input logic wr, input logic rd, input logic req, input logic bstb,
                                 input logic [7:0] bval, input logic all, input logic crc);
        write_data4_strobe = wr;
        read_data4_strobe  = rd;
        response_data_req  = req;
        read_byte_strobe   = bstb;
        read_byte          = bval;
        read_all_strobe    = all;
        read_crc_ok4       = crc;
        @(posedge clock);
        #1;
        write_data4_strobe = 1'b0;
        read_data4_strobe  = 1'b0;
        response_data_req  = 1'b0;
        read_byte_strobe   = 1'b0;
        read_byte          = 8'h00;
        read_all_strobe    = 1'b0;
        read_crc_ok4       = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle_cycles(n);
        reset = 1'b0;
        model_overflow = 1'b0;
    endtask

    // Transmit: the host sees buffer bytes 0..n-1 in order, then one empty.
    task automatic run_tx(input int cnt, input bit collide, input bit force_mid_err);
        int n;
        int r;
        bit s_wr;
        bit s_rd;
        n = (cnt == 0) ? 512 : cnt;
        data4_count = type_data4_count'(cnt);
        q_start.push_back(mk(cyc + SD, 1));
        if (collide) q_perr.push_back(mk(cyc + 1, 1));
        applyStimulus(1'b1, collide, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("tx busy", int'(busy), 1);
        idle_cycles(SD);
        for (int i = 0; i <= n; i++) begin
            idle_cycles(int'($urandom_range(0, 2)));
            r = cyc;
            if (i < n) begin
                checkOutput("tx mem_addr", int'(mem_addr), i);
                q_strobe.push_back(mk(r + 2, int'(buffer[i])));
                applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
                s_wr = (force_mid_err && i == 1) || ($urandom_range(0, 15) == 0);
                s_rd = (force_mid_err && i == 2) || ($urandom_range(0, 15) == 0);
                if (s_wr || s_rd) q_perr.push_back(mk(r + 2, 1));
                applyStimulus(s_wr, s_rd, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0, 1'b0);
                applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                q_empty.push_back(mk(r + 1, 1));
                q_txdone.push_back(mk(r + 1, 1));
                applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
                idle_cycles(1);
            end
        end
        checkOutput("tx busy after done", int'(busy), 0);
    endtask

    // Receive: the first n bytes land at addresses 0..n-1, extras flag overflow.
    task automatic run_rx(input int cnt, input int nbytes, input bit crc,
                          input bit all_with_last, input int abort_after);
        int n;
        logic [7:0] v;
        bit last_all;
        n = (cnt == 0) ? 512 : cnt;
        data4_count = type_data4_count'(cnt);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rx busy", int'(busy), 1);
        checkOutput("rx crc cleared", int'(rx_crc_ok), 0);
        for (int b = 0; b < nbytes; b++) begin
            if (b == abort_after) begin
                do_reset(2);
                checkOutput("abort busy", int'(busy), 0);
                checkOutput("abort mem_addr", int'(mem_addr), 0);
                checkOutput("abort rx_crc_ok", int'(rx_crc_ok), 0);
                checkOutput("abort rx_overflow", int'(rx_overflow), 0);
                idle_cycles(2);
                return;
            end
            repeat ($urandom_range(0, 2))
                applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0, 1'b0);
            v = (byte_q.size() > 0) ? byte_q.pop_front() : 8'($urandom);
            last_all = all_with_last && (b == nbytes - 1);
            if (b < n) q_wr.push_back(mk(cyc, b * 256 + int'(v)));
            else       model_overflow = 1'b1;
            if (last_all) q_rxdone.push_back(mk(cyc + 1, 1));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, v, last_all, crc);
        end
        if (!(all_with_last && nbytes > 0)) begin
            q_rxdone.push_back(mk(cyc + 1, 1));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, crc);
        end
        idle_cycles(1);
        checkOutput("rx_crc_ok", int'(rx_crc_ok), int'(crc));
        checkOutput("rx_overflow", int'(rx_overflow), int'(model_overflow));
        checkOutput("rx busy after done", int'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        int nb;
        for (int i = 0; i < 512; i++) buffer[i] = 8'($urandom);
        do_reset(3);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset response_data", int'(response_data), 0);
        checkOutput("reset mem_addr", int'(mem_addr), 0);
        checkOutput("reset mem_wr_en", int'(mem_wr_en), 0);
        checkOutput("reset rx_crc_ok", int'(rx_crc_ok), 0);
        checkOutput("reset rx_overflow", int'(rx_overflow), 0);
        checkOutput("reset tx_done", int'(tx_done), 0);
        checkOutput("reset proto_error", int'(proto_error), 0);

        $display("[TB] transmit of four known bytes");
        buffer[0] = 8'h11; buffer[1] = 8'h22; buffer[2] = 8'h33; buffer[3] = 8'h44;
        run_tx(4, 1'b0, 1'b0);

        $display("[TB] receive three bytes, good crc");
        byte_q.push_back(8'hA5); byte_q.push_back(8'h5A); byte_q.push_back(8'hFF);
        run_rx(3, 3, 1'b1, 1'b0, -1);

        $display("[TB] receive overflow, bad crc");
        run_rx(2, 3, 1'b0, 1'b0, -1);

        $display("[TB] colliding data4 strobes and strobes during transmit");
        run_tx(5, 1'b1, 1'b1);

        $display("[TB] full 512-byte transmit");
        for (int i = 0; i < 512; i++) buffer[i] = 8'($urandom);
        run_tx(0, 1'b0, 1'b0);

        $display("[TB] reset during receive, then fresh receive");
        run_rx(6, 4, 1'b1, 1'b0, 2);
        run_rx(3, 3, 1'b1, 1'b1, -1);

        $display("[TB] randomized transfers");
        for (int k = 0; k < 10; k++) begin
            cnt = int'($urandom_range(1, 16));
            if ($urandom_range(0, 1) == 1) begin
                run_tx(cnt, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                nb = cnt - 1 + int'($urandom_range(0, 3));
                run_rx(cnt, nb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            end
            idle_cycles(int'($urandom_range(0, 3)));
        end

        idle_cycles(4);
        checkOutput("leftover start_write", q_start.size(), 0);
        checkOutput("leftover data_strobe", q_strobe.size(), 0);
        checkOutput("leftover data_empty", q_empty.size(), 0);
        checkOutput("leftover tx_done", q_txdone.size(), 0);
        checkOutput("leftover rx_done", q_rxdone.size(), 0);
        checkOutput("leftover mem_write", q_wr.size(), 0);
        checkOutput("leftover proto_error", q_perr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdio_data_sequencer.md
SDIO_DATA_SEQUENCER -- requirements
Module: sdio_data_sequencer

Interface
REQ-001 SHALL have parameter START_DELAY, default 2, giving the number of cycles from transmit request to the response_start_write pulse (range 1..15).
REQ-002 SHALL have ports clock (in, 1, system clock) and reset (in, 1, synchronous active-high reset); one clock, reset is synchronous and active-high.
REQ-003 SHALL have ports data4_count (in, type_data4_count, byte count from the command processor), write_data4_strobe (in, 1) and read_data4_strobe (in, 1).
REQ-004 SHALL have ports response_start_write (out, 1), response_data_req (in, 1), response_data_strobe (out, 1), response_data_empty (out, 1) and response_data (out, 8).
REQ-005 SHALL have ports read_byte_strobe (in, 1), read_byte (in, 8), read_all_strobe (in, 1) and read_crc_ok4 (in, 1).
REQ-006 SHALL have ports mem_addr (out, 9, byte buffer address), mem_rd_data (in, 8, valid one cycle after mem_addr), mem_wr_en (out, 1) and mem_wr_data (out, 8).
REQ-007 SHALL have ports busy (out, 1), tx_done (out, 1, pulse), rx_done (out, 1, pulse), rx_crc_ok (out, 1, held), rx_overflow (out, 1, sticky) and proto_error (out, 1, pulse).

Function
REQ-008 SHALL implement the states IDLE, TX_DELAY, TX_WAIT, TX_FETCH, TX_PRESENT, RX_RECV.
REQ-009 SHALL, in IDLE, on write_data4_strobe, latch the count, clear the byte index, and enter TX_DELAY; count 0 is treated as 512.
REQ-010 SHALL pulse response_start_write for exactly 1 cycle, START_DELAY cycles after the strobe, then enter TX_WAIT.
REQ-011 SHALL, in TX_WAIT, on response_data_req with index < count, drive mem_addr=index that cycle and enter TX_FETCH.
REQ-012 SHALL, in TX_FETCH, register mem_rd_data, then in TX_PRESENT drive response_data and pulse response_data_strobe for 1 cycle (req→strobe latency exactly 2 cycles), increment the index, and return to TX_WAIT.
REQ-013 SHALL, on response_data_req with index == count, pulse response_data_empty one cycle later, pulse tx_done with it, and return to IDLE.
REQ-014 SHALL, in IDLE, on read_data4_strobe, latch the count, clear the index, clear rx_crc_ok, and enter RX_RECV.
REQ-015 SHALL, on each read_byte_strobe in RX_RECV with index < count, assert mem_wr_en for 1 cycle with mem_addr=index and mem_wr_data=read_byte (same cycle, combinational from the registered index), then increment the index.
REQ-016 SHALL, on read_byte_strobe with index >= count, suppress the write and set rx_overflow.
REQ-017 SHALL, on read_all_strobe in RX_RECV, latch rx_crc_ok=read_crc_ok4, pulse rx_done the next cycle, and return to IDLE; a same-cycle read_byte_strobe is written first.
REQ-018 SHALL give write_data4_strobe priority when it arrives simultaneously with read_data4_strobe in IDLE; the read strobe is dropped and proto_error pulses.
REQ-019 SHALL ignore any data4 strobe received outside IDLE (no state change) and pulse proto_error.
REQ-020 SHALL ignore response_data_req outside TX_WAIT, and read_byte_strobe or read_all_strobe outside RX_RECV.
REQ-021 SHALL drive busy=1 in every state except IDLE.
REQ-022 SHALL keep the index 10 bits wide so that a count of 512 does not wrap; mem_addr is index[8:0].

Reset
REQ-023 SHALL, on reset, force state to IDLE, index and count to 0, all pulse outputs to 0, mem_wr_en to 0, rx_crc_ok to 0, rx_overflow to 0, busy to 0, and response_data and mem_addr to 0.
REQ-024 SHALL abort any transfer on reset mid-operation, with no tx_done, rx_done or empty pulse generated.

Structure
REQ-025 SHALL take type_data4_count (10-bit) and the state enum from the shared SDIO package; START_DELAY stays a local parameter.
REQ-026 SHALL be a single module with no sub-modules; the byte buffer RAM is external.

Verification
REQ-027 SHALL cover TX count=4, buffer 0x11..0x44, 5 reqs: START pulse at strobe+2; each strobe exactly 2 cycles after its req with data 0x11, 0x22, 0x33, 0x44; 5th req → empty and tx_done once.
REQ-028 SHALL cover RX count=3, bytes 0xA5, 0x5A, 0xFF, then all_strobe with crc_ok=1: writes to addr 0..2, rx_done pulses, rx_crc_ok=1, rx_overflow=0.
REQ-029 SHALL cover RX count=2 with 3 bytes and crc_ok=0: only addr 0..1 written, rx_overflow=1, rx_crc_ok=0.
REQ-030 SHALL cover simultaneous write and read strobes in IDLE: TX starts, proto_error pulses once; a read strobe during TX → proto_error, TX unaffected.
REQ-031 SHALL cover TX count=0: exactly 512 strobes, addresses 0..511, then empty.
REQ-032 SHALL cover reset asserted after the 2nd RX byte: state IDLE, busy=0, no rx_done; a new RX after reset starts at addr 0.
